// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: fetch PC, 1-cycle ROM reads, 2-entry prefetch FIFO, redirect flush.
// Optional FETCH_HALT_ON_EBREAK_EN: stop fetching after an EBREAK word is buffered.
module instr_fetch_unit #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              halted
);
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        run;
    logic [31:0] fetch_pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic [31:0] word1, pc1;
    logic [1:0]  occ, occ_next;
    logic [2:0]  credit;
    logic        pop, push;

`ifndef FETCH_HALT_ON_EBREAK_EN
    assign halted = 1'b0;
`endif

    assign pop      = instr_valid && instr_ready;
    // A returning word after the halt point belongs to the abandoned stream.
    assign push     = inflight && !halted;
    assign mem_addr = fetch_pc[ADDR_W+1:2];

    // Credit counts words that will occupy the FIFO once the next edge settles.
    assign credit    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign mem_rd_en = resetn && run && !halted && !redirect && (credit < 3'd2);

    always_comb begin
        occ_next = occ;
        if (push && !pop)
            occ_next = occ + 2'd1;
        else if (pop && !push)
            occ_next = occ - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            occ         <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            word1       <= '0;
            pc1         <= '0;
`ifdef FETCH_HALT_ON_EBREAK_EN
            halted      <= 1'b0;
`endif
        end else begin
            run <= 1'b1;
            if (redirect) begin
                occ         <= '0;
                instr_valid <= 1'b0;
                inflight    <= 1'b0;
                fetch_pc    <= {redirect_pc[31:2], 2'b00};
`ifdef FETCH_HALT_ON_EBREAK_EN
                halted      <= 1'b0;
`endif
            end else begin
                occ         <= occ_next;
                instr_valid <= (occ_next != 2'd0);
                inflight    <= mem_rd_en;
                if (mem_rd_en) begin
                    inflight_pc <= fetch_pc;
                    fetch_pc    <= fetch_pc + 32'd4;
                end
                if (pop && occ == 2'd2) begin
                    instr    <= word1;
                    instr_pc <= pc1;
                end
                // New word lands in the first slot left free after this edge's pop.
                if (push) begin
                    if ((occ - {1'b0, pop}) == 2'd0) begin
                        instr    <= mem_rdata;
                        instr_pc <= inflight_pc;
                    end else begin
                        word1 <= mem_rdata;
                        pc1   <= inflight_pc;
                    end
                end
`ifdef FETCH_HALT_ON_EBREAK_EN
                if (push && mem_rdata == EBREAK)
                    halted <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front-end feeding the multi-cycle RV32I core's decode/execute state machine. Owns the fetch PC, issues reads to a synchronous one-cycle-latency instruction ROM, buffers returned words in a 2-entry prefetch FIFO and presents them to the core over a valid/ready handshake. Accepts redirects (jumps/branches) from the core, flushing buffered and in-flight words.

## Interface
- ADDR_W, 8: word-address width of instruction ROM (ROM holds 2^ADDR_W words)
- RESET_PC, 32'h0: fetch PC after reset; bits [1:0] must be 0
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- mem_rd_en  out  1  ROM read strobe; ROM samples mem_addr on clk edge when high
- mem_addr  out  ADDR_W  word address, = fetch_pc[ADDR_W+1:2]
- mem_rdata  in  32  ROM data, valid the cycle after the sampling edge
- instr  out  32  head-of-FIFO instruction word
- instr_pc  out  32  byte address of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  core accepts head when instr_valid && instr_ready
- redirect  in  1  one-cycle pulse: discard everything, restart at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- halted  out  1  fetch stopped on EBREAK (see Configuration)

## Operation
- Registers: run (0 in reset), fetch_pc, inflight (1 bit) + inflight_pc, FIFO 2 x {word, pc}, occ (0..2), halted.
- Reset (resetn=0 at an edge): run=0, fetch_pc=RESET_PC, occ=0, inflight=0, halted=0. Outputs during/after reset: mem_rd_en=0, instr_valid=0, instr=0, instr_pc=0, halted=0. Reset mid-operation drops all buffered and in-flight words.
- run set on first edge sampling resetn=1.
- pop = instr_valid && instr_ready.
- mem_rd_en (combinational) = run && !halted && !redirect && (occ + inflight - pop < 2).
- On edge with mem_rd_en=1: inflight=1, inflight_pc=fetch_pc, fetch_pc += 4 (32-bit wrap, 32'hFFFFFFFC -> 0).
- On edge with inflight=1 and no redirect: push {mem_rdata, inflight_pc} into FIFO; inflight cleared unless a new read issued same edge.
- Simultaneous push and pop: occ unchanged; order preserved (FIFO, oldest at head).
- FIFO full (occ=2): no issue; credit check guarantees no push when full.
- Empty: instr_valid=0; instr/instr_pc hold last head value (don't-care for verification).
- mem_addr wraps modulo 2^ADDR_W words; instr_pc always carries full 32-bit fetch_pc.
- Redirect (sampled at edge R): occ=0, inflight=0 (returning word at R+1 discarded), fetch_pc=redirect_pc & ~3, halted=0. A pop in the same cycle as redirect completes (core consumed head) before the flush.
- redirect while resetn=0: ignored; reset wins.

## Timing
- Reset release: edge E0 samples resetn=1 -> mem_rd_en=1 in cycle E0..E1 -> ROM samples at E1 -> word pushed at E2 -> instr_valid=1 after E2 (2 cycles after E0 + 1).
- Redirect at edge R: instr_valid=0 after R; first new read sampled at R+1; instr_valid=1 after R+2.
- Steady state with instr_ready held 1: one instruction per cycle, no bubbles.
- instr_ready=0: unit fills to occ=2 then stalls with mem_rd_en=0; resumes issue in the cycle ready returns.
- All outputs except mem_rd_en/mem_addr are registered; mem_rd_en depends combinationally on instr_ready and redirect.

## Configuration
- FETCH_HALT_ON_EBREAK_EN defined: when a pushed word equals 32'h00100073 (EBREAK), halted=1 from the next cycle; no further reads issued; any read in flight at that moment is discarded on return. EBREAK itself is still delivered to the core. halted cleared only by redirect or reset.
- Undefined: halted tied 0; EBREAK treated as an ordinary word; fetch continues sequentially.

## Test plan
- Reset release, ROM[i]=i+0x100, ready=1 -> instr_valid after 2 edges post-release; instr sequence 0x100,0x101,0x102 with instr_pc 0,4,8 on consecutive cycles.
- ready=0 for 5 cycles after first valid -> occ saturates at 2, mem_rd_en=0, instr/instr_pc stay 0x100/0; on ready=1 sequence continues with no gaps or duplicates.
- Redirect pulse with redirect_pc=0x41 while occ=2 and a read in flight -> instr_valid=0 next cycle; next delivered instr_pc=0x40, instr=ROM[16]; no stale word appears.
- RESET_PC=0x3F8, ADDR_W=8 -> instr_pc 0x3F8,0x3FC,0x400 with mem_addr 254,255,0 (wrap).
- resetn low for 1 cycle mid-stream with occ=2 -> instr_valid=0, halted=0 next cycle; restart from RESET_PC.
- With FETCH_HALT_ON_EBREAK_EN, ROM[3]=32'h00100073 -> words 0..3 delivered, halted=1, no word 4 delivered; redirect to 0 clears halted and refetches word 0.
